// File: rtl/fu_req_queue.sv
// In-order request queue in front of one functional unit: buffers issue packets and
// presents them head-first to the FU. Build option FU_REQ_QUEUE_BYPASS_EN adds an empty-queue bypass.
package fu_req_queue_pkg;
   typedef struct packed {
      logic        valid;
      logic [4:0]  rob_idx;
      logic [3:0]  op;
      logic [31:0] src_a;
      logic [31:0] src_b;
      logic [5:0]  dest_preg;
   } issue_packet_t;
endpackage

module fu_req_queue
   import fu_req_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  issue_packet_t    req_i,
   output logic             ready_o,
   input  logic             flush_i,
   output issue_packet_t    fu_pkt_o,
   output logic             fu_valid_o,
   input  logic             fu_accept_i,
   output logic [CNT_W-1:0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   issue_packet_t    mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             stored_valid;
   logic             push;
   logic             pop;

   // Handshakes: a request transfers when req_i.valid && ready_o, a head packet
   // transfers when fu_valid_o && fu_accept_i; flush_i cancels both in its cycle.
   // ready_o is taken from registered count only, so it never depends on req_i or fu_accept_i.
   assign ready_o      = (count < CNT_W'(DEPTH));
   assign stored_valid = (count != '0);
   assign count_o      = count;

`ifdef FU_REQ_QUEUE_BYPASS_EN
   logic bypass;

   // Empty queue: the incoming request is shown to the FU in the same cycle and
   // only written if the FU does not take it right away.
   assign bypass     = !stored_valid && req_i.valid && !flush_i;
   assign fu_valid_o = stored_valid || bypass;
   assign fu_pkt_o   = stored_valid ? mem[head] : (bypass ? req_i : '0);
   assign push       = req_i.valid && ready_o && !flush_i && !(bypass && fu_accept_i);
   assign pop        = stored_valid && fu_accept_i && !flush_i;
`else
   assign fu_valid_o = stored_valid;
   assign fu_pkt_o   = stored_valid ? mem[head] : '0;
   assign push       = req_i.valid && ready_o && !flush_i;
   assign pop        = fu_valid_o && fu_accept_i && !flush_i;
`endif

   // Storage carries no reset; count alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[tail] <= req_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_fu_req_queue.sv
// Directed bench for fu_req_queue: reset, fill/drain, concurrent push/pop,
// flush, full-queue push+pop and the empty-queue bypass (FU_REQ_QUEUE_BYPASS_EN).
module tb_fu_req_queue;
   import fu_req_queue_pkg::*;

   logic          clock;
   logic          reset;
   issue_packet_t req_i;
   logic          ready_o;
   logic          flush_i;
   issue_packet_t fu_pkt_o;
   logic          fu_valid_o;
   logic          fu_accept_i;
   logic [2:0]    count_o;

   int checks;
   int errors;
   logic [4:0] exp_q[$];

   fu_req_queue #(.DEPTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_i       (req_i),
      .ready_o     (ready_o),
      .flush_i     (flush_i),
      .fu_pkt_o    (fu_pkt_o),
      .fu_valid_o  (fu_valid_o),
      .fu_accept_i (fu_accept_i),
      .count_o     (count_o)
   );

   // Clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic issue_packet_t mk(input logic [4:0] rob);
      issue_packet_t p;
      p           = '0;
      p.valid     = 1'b1;
      p.rob_idx   = rob;
      p.op        = rob[3:0] ^ 4'h5;
      p.src_a     = {rob, 27'h1234567};
      p.src_b     = {27'h0, rob} + 32'hA000_0000;
      p.dest_preg = {1'b0, rob};
      return p;
   endfunction

   // Driver tasks: inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      req_i       = '0;
      flush_i     = 1'b0;
      fu_accept_i = 1'b0;
   endtask

   task automatic push_n(input logic [4:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         req_i = mk(first + 5'(i));
         step();
      end
      req_i = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
      checks++;
      if (fu_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fu_valid_o); end
      checks++;
      if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
      checks++;
      if (fu_pkt_o !== '0) begin errors++; $display("FAIL reset_pkt got %h exp 0", fu_pkt_o); end
      // Reset in the middle of traffic empties the queue.
      step();
      push_n(5'd3, 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (count_o !== 3'd0 || fu_valid_o !== 1'b0) begin
         errors++; $display("FAIL midreset got count %0d valid %b exp 0 0", count_o, fu_valid_o);
      end
   endtask

   task automatic test_fill_drain();
      idle_inputs();
      push_n(5'd1, 4);
      checks++;
      if (count_o !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count_o); end
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", ready_o); end
      req_i = mk(5'd5);
      step();
      req_i = '0;
      checks++;
      if (count_o !== 3'd4) begin errors++; $display("FAIL fill_reject got %0d exp 4", count_o); end
      fu_accept_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++;
         if (fu_valid_o !== 1'b1 || fu_pkt_o !== mk(5'(i))) begin
            errors++; $display("FAIL drain_%0d got v%b rob %0d exp v1 rob %0d", i, fu_valid_o, fu_pkt_o.rob_idx, i);
         end
         step();
         if (i == 1) begin
            checks++;
            if (ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", ready_o); end
         end
      end
      fu_accept_i = 1'b0;
      checks++;
      if (count_o !== 3'd0 || fu_valid_o !== 1'b0) begin
         errors++; $display("FAIL drain_empty got count %0d valid %b exp 0 0", count_o, fu_valid_o);
      end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      exp_q.delete();
      push_n(5'd11, 2);
      exp_q.push_back(5'd11);
      exp_q.push_back(5'd12);
      fu_accept_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req_i = mk(5'd13 + 5'(i));
         #1;
         checks++;
         if (count_o !== 3'd2) begin errors++; $display("FAIL b2b_count_%0d got %0d exp 2", i, count_o); end
         checks++;
         if (fu_pkt_o !== mk(exp_q[0])) begin
            errors++; $display("FAIL b2b_head_%0d got rob %0d exp rob %0d", i, fu_pkt_o.rob_idx, exp_q[0]);
         end
         void'(exp_q.pop_front());
         exp_q.push_back(5'd13 + 5'(i));
         step();
      end
      req_i = '0;
      while (exp_q.size() > 0) begin
         #1;
         checks++;
         if (fu_valid_o !== 1'b1 || fu_pkt_o !== mk(exp_q[0])) begin
            errors++; $display("FAIL b2b_tail got v%b rob %0d exp rob %0d", fu_valid_o, fu_pkt_o.rob_idx, exp_q[0]);
         end
         void'(exp_q.pop_front());
         step();
      end
      fu_accept_i = 1'b0;
      checks++;
      if (count_o !== 3'd0) begin errors++; $display("FAIL b2b_end got %0d exp 0", count_o); end
   endtask

   task automatic test_flush();
      idle_inputs();
      push_n(5'd21, 3);
      checks++;
      if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", count_o); end
      flush_i     = 1'b1;
      req_i       = mk(5'd9);
      fu_accept_i = 1'b1;
      step();
      flush_i     = 1'b0;
      req_i       = '0;
      checks++;
      if (count_o !== 3'd0 || fu_valid_o !== 1'b0 || fu_pkt_o !== '0) begin
         errors++; $display("FAIL flush_empty got count %0d valid %b rob %0d exp 0 0 0", count_o, fu_valid_o, fu_pkt_o.rob_idx);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (fu_valid_o !== 1'b0) begin errors++; $display("FAIL flush_leak got valid %b rob %0d exp 0", fu_valid_o, fu_pkt_o.rob_idx); end
      end
      fu_accept_i = 1'b0;
   endtask

   task automatic test_full_push_pop();
      idle_inputs();
      push_n(5'd1, 4);
      fu_accept_i = 1'b1;
      req_i       = mk(5'd5);
      #1;
      checks++;
      if (fu_pkt_o !== mk(5'd1)) begin errors++; $display("FAIL full_head got rob %0d exp 1", fu_pkt_o.rob_idx); end
      step();
      req_i = '0;
      checks++;
      if (count_o !== 3'd3) begin errors++; $display("FAIL full_count got %0d exp 3", count_o); end
      for (int i = 2; i <= 4; i++) begin
         #1;
         checks++;
         if (fu_valid_o !== 1'b1 || fu_pkt_o !== mk(5'(i))) begin
            errors++; $display("FAIL full_drain_%0d got v%b rob %0d exp rob %0d", i, fu_valid_o, fu_pkt_o.rob_idx, i);
         end
         step();
      end
      checks++;
      if (fu_valid_o !== 1'b0 || count_o !== 3'd0) begin
         errors++; $display("FAIL full_no5 got valid %b rob %0d count %0d exp 0", fu_valid_o, fu_pkt_o.rob_idx, count_o);
      end
      fu_accept_i = 1'b0;
   endtask

   task automatic test_bypass();
      idle_inputs();
      req_i       = mk(5'd7);
      fu_accept_i = 1'b1;
      #1;
`ifdef FU_REQ_QUEUE_BYPASS_EN
      checks++;
      if (fu_valid_o !== 1'b1 || fu_pkt_o.rob_idx !== 5'd7) begin
         errors++; $display("FAIL byp_same got v%b rob %0d exp v1 rob 7", fu_valid_o, fu_pkt_o.rob_idx);
      end
      step();
      req_i = '0;
      checks++;
      if (count_o !== 3'd0 || fu_valid_o !== 1'b0) begin
         errors++; $display("FAIL byp_next got count %0d valid %b exp 0 0", count_o, fu_valid_o);
      end
`else
      checks++;
      if (fu_valid_o !== 1'b0) begin errors++; $display("FAIL nobyp_same got valid %b exp 0", fu_valid_o); end
      step();
      req_i = '0;
      checks++;
      if (count_o !== 3'd1 || fu_valid_o !== 1'b1 || fu_pkt_o.rob_idx !== 5'd7) begin
         errors++; $display("FAIL nobyp_next got count %0d v%b rob %0d exp 1 1 7", count_o, fu_valid_o, fu_pkt_o.rob_idx);
      end
      step();
      checks++;
      if (count_o !== 3'd0) begin errors++; $display("FAIL nobyp_pop got %0d exp 0", count_o); end
`endif
      fu_accept_i = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle_inputs();
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_full_push_pop();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
